// File: rtl/accel_buffer_mc.sv
// ---------------------------------------------------------------------------
// accel_buffer_mc
//   Multi-channel stream buffer. Inbound words are steered by s_tdest into one
//   of NUM_CH independent FIFOs. A round-robin arbiter selects a non-empty
//   channel and moves its head word into a single outbound register stage.
//
// Handshake: a word moves across an interface on a rising accel_clk edge where
//   valid && ready are both high. Once m_tvalid is high, m_tvalid, m_tdata,
//   m_tdest and m_tlast hold until m_tready is seen. s_tready is combinational
//   from the occupancy of the addressed channel and does not depend on s_tvalid.
//
// Optional feature (macro ACCEL_BUF_PKT_LOCK_EN):
//   Packet lock. Once the arbiter pops a word with tlast=0, it serves only
//   that channel until that channel's tlast=1 word is popped. Without the
//   macro, every word is arbitrated on its own.
//
// Ports:
//   accel_clk, accel_rst       clock, asynchronous active-high reset
//   s_tdata/tdest/tlast/tvalid inbound stream; s_tready back-pressure
//   m_tdata/tdest/tlast/tvalid outbound stream; m_tready back-pressure
//   buff_full, buff_empty      per-channel flags (programmable or true)
// ---------------------------------------------------------------------------
module accel_buffer_mc #(
    parameter int NUM_CH       = 4,
    parameter int BUFF_DEPTH   = 16,
    parameter int BUFF_WORD    = 32,
    parameter int PROG_SUPPORT = 1,
    parameter int PROG_FULL_N  = 5,
    parameter int PROG_EMPTY_N = 5,
    parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 accel_clk,
    input  logic                 accel_rst,
    input  logic [BUFF_WORD-1:0] s_tdata,
    input  logic [CH_W-1:0]      s_tdest,
    input  logic                 s_tlast,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    output logic [BUFF_WORD-1:0] m_tdata,
    output logic [CH_W-1:0]      m_tdest,
    output logic                 m_tlast,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [NUM_CH-1:0]    buff_full,
    output logic [NUM_CH-1:0]    buff_empty
);

    localparam int PTR_W = $clog2(BUFF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(BUFF_DEPTH);
    localparam logic [CNT_W-1:0] PFULL_C  = CNT_W'(BUFF_DEPTH - PROG_FULL_N);
    localparam logic [CNT_W-1:0] PEMPTY_C = CNT_W'(PROG_EMPTY_N);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

    logic [CNT_W-1:0]   cnt    [NUM_CH];
    logic [PTR_W-1:0]   wr_ptr [NUM_CH];
    logic [PTR_W-1:0]   rd_ptr [NUM_CH];
    // Entry layout: {tlast, tdata}. Storage is deliberately not reset.
    logic [BUFF_WORD:0] mem    [NUM_CH][BUFF_DEPTH];

    logic              dest_ok;
    logic              dest_full;
    logic              wr_en;
    logic [NUM_CH-1:0] wr_sel;
    logic [NUM_CH-1:0] rd_sel;
    logic              grant_valid;
    logic [CH_W-1:0]   grant_ch;
    logic [CH_W-1:0]   last_grant;
    logic [BUFF_WORD:0] head;
    logic              pop;
    logic              lock_active;
    logic [CH_W-1:0]   lock_ch;

    // ------------------------------------------------------------------
    // Inbound side. Destinations beyond NUM_CH are accepted and dropped so
    // a stray tdest can never stall the upstream.
    // ------------------------------------------------------------------
    generate
        if (NUM_CH == (1 << CH_W)) begin : g_dest_all
            assign dest_ok = 1'b1;
        end else begin : g_dest_range
            assign dest_ok = ({1'b0, s_tdest} < (CH_W + 1)'(NUM_CH));
        end
    endgenerate

    always_comb begin
        dest_full = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (s_tdest == CH_W'(i) && cnt[i] == DEPTH_C) begin
                dest_full = 1'b1;
            end
        end
    end

    // No bypass: a full channel refuses the write even if it pops this cycle.
    assign s_tready = !accel_rst && !dest_full;
    assign wr_en    = s_tvalid && s_tready && dest_ok;

    // ------------------------------------------------------------------
    // Round-robin arbiter: first non-empty channel after last_grant. While
    // a packet lock is held only the locked channel is eligible.
    // ------------------------------------------------------------------
    always_comb begin : arb
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_ch    = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(last_grant) + k) % NUM_CH;
            if (!grant_valid && cnt[idx] != '0 &&
                (!lock_active || CH_W'(idx) == lock_ch)) begin
                grant_valid = 1'b1;
                grant_ch    = CH_W'(idx);
            end
        end
    end

    assign head = mem[grant_ch][rd_ptr[grant_ch]];
    // The output register takes a new word whenever it is empty or draining.
    assign pop  = grant_valid && (!m_tvalid || m_tready);

    always_comb begin
        wr_sel = '0;
        rd_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_sel[i] = wr_en && (s_tdest == CH_W'(i));
            rd_sel[i] = pop && (grant_ch == CH_W'(i));
        end
    end

    // ------------------------------------------------------------------
    // Per-channel occupancy and pointers. Pointers wrap naturally because
    // BUFF_DEPTH is a power of two.
    // ------------------------------------------------------------------
    always_ff @(posedge accel_clk or posedge accel_rst) begin
        if (accel_rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]    <= '0;
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_sel[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (rd_sel[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
                if (wr_sel[i] && !rd_sel[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (!wr_sel[i] && rd_sel[i]) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge accel_clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_sel[i]) begin
                mem[i][wr_ptr[i]] <= {s_tlast, s_tdata};
            end
        end
    end

    // ------------------------------------------------------------------
    // Outbound register stage. last_grant only moves on an actual pop, so
    // an idle period leaves the round-robin position untouched.
    // ------------------------------------------------------------------
    always_ff @(posedge accel_clk or posedge accel_rst) begin
        if (accel_rst) begin
            m_tvalid   <= 1'b0;
            m_tdata    <= '0;
            m_tdest    <= '0;
            m_tlast    <= 1'b0;
            last_grant <= LAST_CH;
        end else if (pop) begin
            m_tvalid   <= 1'b1;
            m_tdata    <= head[BUFF_WORD-1:0];
            m_tlast    <= head[BUFF_WORD];
            m_tdest    <= grant_ch;
            last_grant <= grant_ch;
        end else if (m_tready) begin
            m_tvalid   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Flags
    // ------------------------------------------------------------------
    generate
        if (PROG_SUPPORT != 0) begin : g_prog_flags
            always_comb begin
                for (int i = 0; i < NUM_CH; i++) begin
                    buff_full[i]  = (cnt[i] >= PFULL_C);
                    buff_empty[i] = (cnt[i] <= PEMPTY_C);
                end
            end
        end else begin : g_true_flags
            always_comb begin
                for (int i = 0; i < NUM_CH; i++) begin
                    buff_full[i]  = (cnt[i] == DEPTH_C);
                    buff_empty[i] = (cnt[i] == '0);
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Packet lock
    // ------------------------------------------------------------------
`ifdef ACCEL_BUF_PKT_LOCK_EN
    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} lock_state_t;

    lock_state_t     lock_state;
    lock_state_t     lock_state_next;
    logic [CH_W-1:0] lock_ch_q;
    logic [CH_W-1:0] lock_ch_next;

    always_ff @(posedge accel_clk or posedge accel_rst) begin
        if (accel_rst) begin
            lock_state <= IDLE;
            lock_ch_q  <= '0;
        end else begin
            lock_state <= lock_state_next;
            lock_ch_q  <= lock_ch_next;
        end
    end

    // While LOCKED the arbiter can only grant lock_ch_q, so a popped tlast
    // necessarily comes from the locked channel.
    always_comb begin
        lock_state_next = lock_state;
        lock_ch_next    = lock_ch_q;
        case (lock_state)
            IDLE: begin
                if (pop && !head[BUFF_WORD]) begin
                    lock_state_next = LOCKED;
                    lock_ch_next    = grant_ch;
                end
            end
            LOCKED: begin
                if (pop && head[BUFF_WORD]) begin
                    lock_state_next = IDLE;
                end
            end
            default: lock_state_next = IDLE;
        endcase
    end

    assign lock_active = (lock_state == LOCKED);
    assign lock_ch     = lock_ch_q;
`else
    assign lock_active = 1'b0;
    assign lock_ch     = '0;
`endif

endmodule
